// File: rtl/dmem_arbiter.sv
// dmem_arbiter: bounded-burst round-robin arbiter sharing one single-port data memory between two requesters
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pN_req/we/addr/wdata/mask   port N access request (N = 0 CPU LSU, 1 debug/loader)
//   pN_gnt                      port N accepted this cycle (combinational)
//   pN_rvalid/rdata             port N read response, one cycle after the grant
//   mem_addr/we/mask/wdata      memory drive for the granted access
//   mem_rdata                   memory read data, one cycle after a read
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_mask,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_mask,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [31:0]       p0_rdata,
    output logic [31:0]       p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_mask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);
    logic       owner_q, owner_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_port_q, rd_port_d;
    logic       gnt_any, sel;
    always_comb begin
        // sel is the winning port; with both requesting the owner keeps the port until its burst is used up
        sel         = (p0_req & p1_req) ? ((burst_cnt_q < MAX_B) ? owner_q : ~owner_q) : p1_req;
        gnt_any     = ~rst & (p0_req | p1_req);
        p0_gnt      = gnt_any & ~sel;
        p1_gnt      = gnt_any & sel;
        mem_addr    = p1_gnt ? p1_addr : p0_addr;
        mem_wdata   = p1_gnt ? p1_wdata : p0_wdata;
        mem_we      = gnt_any & (sel ? p1_we : p0_we);
        mem_mask    = gnt_any ? (sel ? p1_mask : p0_mask) : 4'd0;
        owner_d     = gnt_any ? sel : owner_q;
        burst_cnt_d = !gnt_any ? burst_cnt_q :
                      (sel != owner_q) ? 4'd1 :
                      (burst_cnt_q < MAX_B) ? burst_cnt_q + 4'd1 : burst_cnt_q;
        rd_pend_d   = gnt_any & ~mem_we;
        rd_port_d   = gnt_any ? sel : rd_port_q;
        // a response in flight when reset arrives is suppressed immediately
        p0_rvalid   = ~rst & rd_pend_q & ~rd_port_q;
        p1_rvalid   = ~rst & rd_pend_q & rd_port_q;
        p0_rdata    = mem_rdata;
        p1_rdata    = mem_rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            burst_cnt_q <= 4'd0;
            rd_pend_q   <= 1'b0;
            rd_port_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_port_q   <= rd_port_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a one-cycle-latency memory model
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [13:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [3:0]  p0_mask, p1_mask;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [0:16383];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [1:0]  prev_g;
    dmem_arbiter #(.MAX_BURST(4), .ADDR_W(14)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_mask(p0_mask),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_mask(p1_mask),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_mask[i]) mem[mem_addr][8*i+:8] <= mem_wdata[8*i+:8];
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    task automatic smp();
        @(negedge clk);
    endtask
    task automatic idle();
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_mask = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_mask = 0;
    endtask
    task automatic do_reset();
        rst = 1; idle();
        nxt();
        rst = 0;
    endtask
    initial begin
        logic [1:0] cont_exp [12];
        cont_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[14'h0010] = 32'hDEADBEEF;
        mem[14'h3FFF] = 32'hAAAAAAAA;
        mem[14'h0001] = 32'h00000101;
        mem[14'h0002] = 32'h00000202;
        idle();
        rst = 1;
        p0_req = 1; p0_we = 1; p0_addr = 14'h0020; p1_req = 1; p1_we = 1; p1_addr = 14'h0021;
        for (int c = 0; c < 3; c++) begin
            smp();
            check("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
            check("rst_we", {31'd0, mem_we}, 32'd0);
            check("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
            nxt();
        end
        rst = 0;
        smp();
        check("first_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        check("first_mask", {28'd0, mem_mask}, 32'd0);
        nxt();
        idle();
        p0_req = 1; p0_addr = 14'h0010;
        smp();
        check("rd_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        check("rd_addr", {18'd0, mem_addr}, 32'h10);
        nxt();
        idle();
        smp();
        check("rd_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd1);
        check("rd_data", p0_rdata, 32'hDEADBEEF);
        nxt();
        do_reset();
        p0_req = 1; p0_addr = 14'h0001; p1_req = 1; p1_addr = 14'h0002;
        prev_g = 2'd0;
        for (int c = 0; c < 12; c++) begin
            smp();
            check("cont_gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, cont_exp[c]});
            check("cont_rvalid", {30'd0, p1_rvalid, p0_rvalid}, {30'd0, prev_g});
            if (prev_g != 2'd0)
                check("cont_rdata", p0_rdata, prev_g == 2'd1 ? 32'h101 : 32'h202);
            prev_g = cont_exp[c];
            nxt();
        end
        idle();
        p1_req = 1; p1_addr = 14'h0002;
        for (int c = 0; c < 10; c++) begin
            smp();
            check("lone_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd2);
            nxt();
        end
        p0_req = 1; p0_addr = 14'h0001;
        smp();
        check("lone_switch", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        nxt();
        idle();
        p1_req = 1; p1_we = 1; p1_addr = 14'h3FFF; p1_wdata = 32'h11223344; p1_mask = 4'b0101;
        smp();
        check("wr_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd2);
        check("wr_we", {31'd0, mem_we}, 32'd1);
        check("wr_mask", {28'd0, mem_mask}, 32'h5);
        nxt();
        idle();
        p0_req = 1; p0_addr = 14'h3FFF;
        smp();
        check("wr_no_resp", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        nxt();
        idle();
        p1_req = 1; p1_we = 1; p1_addr = 14'h3FFF; p1_wdata = 32'hFFFFFFFF; p1_mask = 4'b0000;
        smp();
        check("wr0_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd2);
        check("wr0_we_mask", {27'd0, mem_we, mem_mask}, 32'h10);
        check("mix_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd1);
        check("masked_data", p0_rdata, 32'hAA22AA44);
        nxt();
        idle();
        p0_req = 1; p0_addr = 14'h3FFF;
        nxt();
        idle();
        smp();
        check("mask0_data", p0_rdata, 32'hAA22AA44);
        check("mask0_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd1);
        nxt();
        p0_req = 1; p0_addr = 14'h0010;
        smp();
        check("rr_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        nxt();
        rst = 1; idle();
        smp();
        check("rr_drop", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        nxt();
        smp();
        check("rr_hold", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        nxt();
        rst = 0;
        p0_req = 1; p0_addr = 14'h0001; p1_req = 1; p1_addr = 14'h0002;
        for (int c = 0; c < 5; c++) begin
            smp();
            check("post_rst_gnt", {30'd0, p1_gnt, p0_gnt}, c < 4 ? 32'd1 : 32'd2);
            if (c == 0) check("post_rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
            nxt();
        end
        idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
